// File: rtl/dwc_rr_arb_if.sv
// Handshake bundle for dwc_rr_arb: N narrow requester streams in, one tagged stream out.
// slave is the arbiter's view; master is the view of the surrounding logic.
interface dwc_rr_arb_if #(
  parameter int N     = 4,
  parameter int DBITS = 8,
  parameter int TBITS = $clog2(N)
);
  logic [N-1:0]       s_axis_tvalid;
  logic [N-1:0]       s_axis_tready;
  logic [N*DBITS-1:0] s_axis_tdata;
  logic               m_axis_tvalid;
  logic               m_axis_tready;
  logic [DBITS-1:0]   m_axis_tdata;
  logic [TBITS-1:0]   m_axis_tdest;
  logic               m_axis_tlast;

  modport slave (
    input  s_axis_tvalid, s_axis_tdata, m_axis_tready,
    output s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tdest, m_axis_tlast
  );

  modport master (
    output s_axis_tvalid, s_axis_tdata, m_axis_tready,
    input  s_axis_tready, m_axis_tvalid, m_axis_tdata, m_axis_tdest, m_axis_tlast
  );
endinterface

// File: rtl/dwc_rr_arb.sv
// Round-robin arbiter granting atomic K-beat bursts from N narrow streams to one width converter.
// Latency: 1 arbitration cycle per burst, then 1 cycle input-to-output through a single output register.
// Backpressure: granted requester's ready = register empty or draining; all other readies held low.
module dwc_rr_arb #(
  parameter int N     = 4,
  parameter int DBITS = 8,
  parameter int K     = 3,
  parameter int TBITS = $clog2(N)
) (
  input  logic         ap_clk,
  input  logic         ap_rst,
  dwc_rr_arb_if.slave  bus
);

  localparam int CBITS = (K > 1) ? $clog2(K) : 1;

  typedef enum logic {IDLE, BURST} state_t;

  typedef struct packed {
    logic [DBITS-1:0] dat;
    logic [TBITS-1:0] dest;
    logic             last;
  } beat_t;

  state_t           state;
  logic [TBITS-1:0] ptr;
  logic [TBITS-1:0] gnt;
  logic [CBITS-1:0] cnt;
  beat_t            out_q;
  logic             out_vld;

  logic             arb_vld;
  logic [TBITS-1:0] arb_gnt;
  logic [TBITS:0]   arb_sum;
  logic [TBITS-1:0] arb_idx;
  logic [TBITS-1:0] nxt_ptr;
  logic             out_free;
  logic             in_xfer;
  logic             cnt_last;
  logic [DBITS-1:0] in_dat;

  // Scan downward so the last hit written is the one closest to ptr in wrap order.
  always_comb begin
    arb_vld = 1'b0;
    arb_gnt = '0;
    arb_sum = '0;
    arb_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      arb_sum = {1'b0, ptr} + (TBITS + 1)'(i);
      if (arb_sum >= (TBITS + 1)'(N))
        arb_sum = arb_sum - (TBITS + 1)'(N);
      arb_idx = arb_sum[TBITS-1:0];
      if (bus.s_axis_tvalid[arb_idx]) begin
        arb_vld = 1'b1;
        arb_gnt = arb_idx;
      end
    end
  end

  assign nxt_ptr  = (gnt == TBITS'(N - 1)) ? '0 : gnt + TBITS'(1);
  assign out_free = !out_vld || bus.m_axis_tready;
  assign in_xfer  = (state == BURST) && out_free && bus.s_axis_tvalid[gnt];
  assign cnt_last = (cnt == CBITS'(K - 1));
  assign in_dat   = bus.s_axis_tdata[int'(gnt) * DBITS +: DBITS];

  assign bus.s_axis_tready = ((state == BURST) && out_free) ? (N'(1) << gnt) : '0;
  assign bus.m_axis_tvalid = out_vld;
  assign bus.m_axis_tdata  = out_q.dat;
  assign bus.m_axis_tdest  = out_q.dest;
  assign bus.m_axis_tlast  = out_q.last;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      cnt     <= '0;
      out_q   <= '0;
      out_vld <= 1'b0;
    end else begin
      // A new beat loaded below takes precedence over this drain.
      if (out_vld && bus.m_axis_tready)
        out_vld <= 1'b0;

      case (state)
        IDLE: begin
          if (arb_vld) begin
            gnt   <= arb_gnt;
            state <= BURST;
          end
        end
        BURST: begin
          if (in_xfer) begin
            out_q   <= '{dat: in_dat, dest: gnt, last: cnt_last};
            out_vld <= 1'b1;
            if (cnt_last) begin
              cnt   <= '0;
              ptr   <= nxt_ptr;
              state <= IDLE;
            end else begin
              cnt <= cnt + CBITS'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dwc_rr_arb.sv
// Bench for dwc_rr_arb: directed scenarios plus random stress, checked by a scoreboard
// fed from a round-robin reference model and a model of the K-beat word assembly downstream.
module tb_dwc_rr_arb;
  localparam int N = 4, DBITS = 8, K = 3, TBITS = 2;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  always #5 ap_clk = ~ap_clk;

  dwc_rr_arb_if #(.N(N), .DBITS(DBITS), .TBITS(TBITS)) bus ();
  dwc_rr_arb #(.N(N), .DBITS(DBITS), .K(K), .TBITS(TBITS)) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bus   (bus)
  );

  typedef logic [DBITS-1:0] bq_t[$];

  int total = 0, bad = 0, cyc = 0;
  bq_t tx_q[N];
  bq_t exp_q[N];
  int  grant_q[$];
  bit  en[N];
  bit  sink_rdy;
  int  acc_cnt[N];
  int  seqn[N];
  int  bursts_done = 0;
  int  xfer_cyc[$], xfer_dest[$];
  logic [DBITS-1:0] xfer_dat[$];

  logic [DBITS-1:0] t1_dat[3] = '{8'h11, 8'h22, 8'h33};
  int t3_dest[9] = '{1, 1, 1, 3, 3, 3, 0, 0, 0};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s: got nothing expected an event (cycle %0d)", name, cyc);
  endtask

  always @(posedge ap_clk) cyc++;

  // Drivers: inputs change only on the falling edge.
  always @(negedge ap_clk) begin
    for (int r = 0; r < N; r++) begin
      bus.s_axis_tvalid[r] = en[r] && (tx_q[r].size() > 0);
      bus.s_axis_tdata[r*DBITS +: DBITS] = (tx_q[r].size() > 0) ? tx_q[r][0] : '0;
    end
    bus.m_axis_tready = sink_rdy;
  end

  // Reference model: round-robin grant from the pointer, K accepted beats per grant.
  bit mb;
  int mown, mptr, mcnt, mj;
  always @(negedge ap_clk) begin
    #1;
    if (ap_rst) begin
      mb = 1'b0; mptr = 0; mcnt = 0;
      grant_q.delete();
      for (int r = 0; r < N; r++) exp_q[r].delete();
    end else begin
      assert ($onehot0(bus.s_axis_tready)) else $error("s_axis_tready not onehot0: %b", bus.s_axis_tready);
      if (!mb) begin
        chk("ready_idle", bus.s_axis_tready, 0);
        for (int i = 0; i < N; i++) begin
          mj = (mptr + i) % N;
          if (!mb && bus.s_axis_tvalid[mj]) begin
            mb = 1'b1; mown = mj; mcnt = 0;
            grant_q.push_back(mj);
          end
        end
      end else begin
        chk("ready_burst", bus.s_axis_tready,
            (!bus.m_axis_tvalid || bus.m_axis_tready) ? (1 << mown) : 0);
        if (bus.s_axis_tvalid[mown] && bus.s_axis_tready[mown]) begin
          exp_q[mown].push_back(tx_q[mown].pop_front());
          acc_cnt[mown]++;
          mcnt++;
          if (mcnt == K) begin
            mb = 1'b0;
            mptr = (mown + 1) % N;
          end
        end
      end
    end
  end

  // Output monitor: per-requester order, burst framing, held-beat stability, assembled word.
  bit prev_hold;
  logic [DBITS-1:0] h_dat, e_dat;
  logic [TBITS-1:0] h_dest;
  logic h_last;
  int bcnt = 0, bdest, od;
  logic [K*DBITS-1:0] word, eword;
  always @(negedge ap_clk) begin
    #1;
    if (ap_rst) begin
      bcnt = 0;
      prev_hold = 1'b0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", bus.m_axis_tvalid, 1);
        chk("hold_data", bus.m_axis_tdata, h_dat);
        chk("hold_dest", bus.m_axis_tdest, h_dest);
        chk("hold_last", bus.m_axis_tlast, h_last);
      end
      if (bus.m_axis_tvalid && bus.m_axis_tready) begin
        od = int'(bus.m_axis_tdest);
        if (bcnt == 0) begin
          word = '0; eword = '0; bdest = od;
          if (grant_q.size() == 0) fail("grant_known");
          else chk("burst_dest", od, grant_q.pop_front());
        end else begin
          chk("dest_const", od, bdest);
        end
        if (exp_q[od].size() == 0) begin
          fail("beat_expected");
        end else begin
          e_dat = exp_q[od].pop_front();
          chk("beat_data", bus.m_axis_tdata, e_dat);
          eword[bcnt*DBITS +: DBITS] = e_dat;
        end
        word[bcnt*DBITS +: DBITS] = bus.m_axis_tdata;
        bcnt++;
        chk("beat_last", bus.m_axis_tlast, (bcnt == K) ? 1 : 0);
        if (bcnt == K) begin
          chk("wide_word", word, eword);
          bcnt = 0;
          bursts_done++;
        end
        xfer_cyc.push_back(cyc);
        xfer_dest.push_back(od);
        xfer_dat.push_back(bus.m_axis_tdata);
      end
      prev_hold = bus.m_axis_tvalid && !bus.m_axis_tready;
      h_dat  = bus.m_axis_tdata;
      h_dest = bus.m_axis_tdest;
      h_last = bus.m_axis_tlast;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge ap_clk);
      #2;
    end
  endtask

  task automatic push_beats(input int r, input int n);
    for (int i = 0; i < n; i++) begin
      tx_q[r].push_back({2'(r), 6'(seqn[r])});
      seqn[r]++;
    end
  endtask

  task automatic clear_logs();
    xfer_cyc.delete(); xfer_dest.delete(); xfer_dat.delete();
  endtask

  task automatic do_reset();
    ap_rst = 1'b1;
    for (int r = 0; r < N; r++) begin
      en[r] = 1'b0;
      tx_q[r].delete();
    end
    tick();
    ap_rst = 1'b0;
    clear_logs();
  endtask

  task automatic wait_bursts(input int target, input string name);
    int lim = 0;
    while (bursts_done < target && lim < 2000) begin
      tick();
      lim++;
    end
    if (bursts_done < target) fail(name);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got no end of test expected completion (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  int c0, base, a0, lim;
  logic [DBITS-1:0] held;

  initial begin
    sink_rdy = 1'b0;
    for (int r = 0; r < N; r++) en[r] = 1'b0;
    tick(2);
    ap_rst = 1'b0;
    chk("rst_m_valid", bus.m_axis_tvalid, 0);
    chk("rst_m_last", bus.m_axis_tlast, 0);
    chk("rst_m_dest", bus.m_axis_tdest, 0);
    chk("rst_s_ready", bus.s_axis_tready, 0);

    // Single requester, first beat 2 cycles after valid rises.
    do_reset();
    sink_rdy = 1'b1;
    for (int i = 0; i < 3; i++) tx_q[2].push_back(t1_dat[i]);
    base = bursts_done;
    c0 = cyc;
    en[2] = 1'b1;
    lim = 0;
    while (xfer_cyc.size() == 0 && lim < 50) begin tick(); lim++; end
    if (xfer_cyc.size() == 0) fail("t1_first_beat");
    else chk("t1_latency", xfer_cyc[0] - c0, 2);
    wait_bursts(base + 1, "t1_burst");
    for (int i = 0; i < 3; i++) begin
      chk("t1_data", xfer_dat[i], t1_dat[i]);
      chk("t1_dest", xfer_dest[i], 2);
    end

    // All requesters valid: rotation order and one bubble per boundary.
    do_reset();
    sink_rdy = 1'b1;
    for (int r = 0; r < N; r++) begin push_beats(r, 6); en[r] = 1'b1; end
    base = bursts_done;
    wait_bursts(base + 8, "t2_bursts");
    for (int b = 0; b < 8; b++) begin
      chk("t2_order", xfer_dest[3*b], b % N);
      if (b > 0) chk("t2_gap", xfer_cyc[3*b] - xfer_cyc[3*b-1], 2);
    end

    // Grant stays locked while the owner stalls; next grant continues from the owner.
    do_reset();
    sink_rdy = 1'b1;
    push_beats(1, 3); push_beats(3, 3); push_beats(0, 3);
    en[1] = 1'b1; en[3] = 1'b1;
    base = bursts_done;
    a0 = acc_cnt[1];
    lim = 0;
    while (acc_cnt[1] == a0 && lim < 50) begin tick(); lim++; end
    if (acc_cnt[1] == a0) fail("t3_first_accept");
    en[1] = 1'b0; en[0] = 1'b1;
    tick(5);
    en[1] = 1'b1;
    wait_bursts(base + 3, "t3_bursts");
    for (int i = 0; i < 9; i++) chk("t3_order", xfer_dest[i], t3_dest[i]);

    // Sink backpressure mid-burst.
    do_reset();
    sink_rdy = 1'b1;
    push_beats(0, 3);
    held = tx_q[0][1];
    en[0] = 1'b1;
    base = bursts_done;
    lim = 0;
    while (xfer_dat.size() == 0 && lim < 50) begin tick(); lim++; end
    if (xfer_dat.size() == 0) fail("t4_first_beat");
    sink_rdy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t4_valid", bus.m_axis_tvalid, 1);
      chk("t4_data", bus.m_axis_tdata, held);
      chk("t4_dest", bus.m_axis_tdest, 0);
      chk("t4_last", bus.m_axis_tlast, 0);
      chk("t4_s_ready", bus.s_axis_tready, 0);
    end
    sink_rdy = 1'b1;
    wait_bursts(base + 1, "t4_burst");

    // Reset in the middle of a burst.
    do_reset();
    sink_rdy = 1'b1;
    push_beats(0, 3);
    en[0] = 1'b1;
    a0 = acc_cnt[0];
    lim = 0;
    while (acc_cnt[0] < a0 + 2 && lim < 50) begin tick(); lim++; end
    if (acc_cnt[0] < a0 + 2) fail("t5_two_beats");
    ap_rst = 1'b1;
    en[0] = 1'b0;
    tick();
    chk("t5_m_valid", bus.m_axis_tvalid, 0);
    chk("t5_s_ready", bus.s_axis_tready, 0);
    ap_rst = 1'b0;
    tx_q[0].delete();
    clear_logs();
    push_beats(1, 3);
    en[1] = 1'b1;
    base = bursts_done;
    wait_bursts(base + 1, "t5_fresh_burst");
    chk("t5_count", xfer_dest.size(), 3);
    for (int i = 0; i < 3; i++) chk("t5_dest", xfer_dest[i], 1);

    // Random stress against the model and word assembly.
    do_reset();
    base = bursts_done;
    lim = 0;
    while (bursts_done < base + 2000 && lim < 40000) begin
      for (int r = 0; r < N; r++) begin
        if (tx_q[r].size() < K) push_beats(r, K);
        en[r] = ($urandom_range(0, 3) != 0);
      end
      sink_rdy = ($urandom_range(0, 9) < 7);
      tick();
      lim++;
    end
    if (bursts_done < base + 2000) fail("stress_bursts");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
